// File: rtl/arty_pkg.sv
// Shared constants, state encodings and baud helper for the Arty UART loader.
package arty_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_ADDR0,
    LD_ADDR1,
    LD_ADDR2,
    LD_ADDR3,
    LD_DATA
  } ld_state_t;

  typedef enum logic [1:0] {
    DP_IDLE,
    DP_READ,
    DP_LOAD,
    DP_SEND
  } dp_state_t;

  // Clock cycles per UART bit.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/arty_uart_phy.sv
// 8N1 UART receive and transmit shifters with their own baud counters.
module arty_uart_phy #(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  logic [1:0]    rx_sync;
  logic          rx_prev;
  logic          rx_busy;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_tick;

  logic          tx_load;
  logic          tx_tick;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [9:0]    tx_shift;

  assign rx_tick = rx_busy && (rx_cnt == '0);
  assign rx_data = rx_shift;

  // Receiver control: edge detect, half-bit offset, bit counting, stop-bit check.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], uart_rx};
      rx_prev  <= rx_sync[1];
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_sync[1]) begin
          rx_busy <= 1'b1;
          rx_cnt  <= HALF;
          rx_bit  <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - CW'(1);
      end else begin
        rx_cnt <= FULL;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0 && rx_sync[1]) begin
          rx_busy <= 1'b0;
        end else if (rx_bit == 4'd9) begin
          rx_busy  <= 1'b0;
          rx_valid <= rx_sync[1];
        end
      end
    end
  end

  // Receiver data: shift in data bits LSB first at each mid-bit sample.
  always_ff @(posedge clk) begin
    if (rx_tick && rx_bit != 4'd0 && rx_bit != 4'd9) begin
      rx_shift <= {rx_sync[1], rx_shift[7:1]};
    end
  end

  assign tx_load = tx_start && !tx_busy;
  assign tx_tick = tx_busy && (tx_cnt == '0);
  assign uart_tx = tx_busy ? tx_shift[0] : 1'b1;

  // Transmitter control: ten bit periods per frame, busy until stop bit ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (tx_load) begin
      tx_busy <= 1'b1;
      tx_cnt  <= FULL;
      tx_bit  <= '0;
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - CW'(1);
      end else begin
        tx_cnt <= FULL;
        tx_bit <= tx_bit + 4'd1;
        if (tx_bit == 4'd9) tx_busy <= 1'b0;
      end
    end
  end

  // Transmitter data: load start/data/stop frame, shift out LSB first.
  always_ff @(posedge clk) begin
    if (tx_load) begin
      tx_shift <= {1'b1, tx_data, 1'b0};
    end else if (tx_tick) begin
      tx_shift <= {1'b1, tx_shift[9:1]};
    end
  end

endmodule

// File: rtl/arty_uart_loader_top.sv
// Arty board top: UART program loader into word RAM, and a byte console dump.
module arty_uart_loader_top
  import arty_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int MEM_WORDS   = 4096,
  parameter int LOCK_CYCLES = 64
) (
  input  logic       xtal_in,
  input  logic [3:0] btn,
  input  logic [3:0] sw,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [3:0] led
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int AW       = $clog2(MEM_WORDS);
  localparam int LCW      = $clog2(LOCK_CYCLES + 1);

  logic rst;
  logic unused_inputs;
  assign rst           = btn[3];
  assign unused_inputs = ^{btn[2:0], sw[2:0]};

  logic           locked;
  logic [LCW-1:0] lock_cnt;
  logic [1:0]     sw_sync;
  logic           sw_prev;
  logic           fetch_rise;
  logic           fetch_seen;

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_take;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_busy;

  ld_state_t      ld_state, ld_next;
  logic [31:0]    ld_addr, addr_next, addr_inc;
  logic [31:0]    ld_word, word_next;
  logic [1:0]     ld_cnt, cnt_next;
  logic           first_word, first_next;
  logic           held, held_next;
  logic           wr_en, wr_en_next;
  logic [AW-1:0]  wr_idx, wr_idx_next;
  logic [31:0]    wr_data, wr_data_next;

  dp_state_t      dp_state, dp_next;
  logic [AW-1:0]  rd_idx, rd_idx_next;
  logic [1:0]     dp_bidx, bidx_next;
  logic [31:0]    dp_word;
  logic [31:0]    rd_data;
  logic           rd_req;

  logic [31:0]    mem [MEM_WORDS];

  arty_uart_phy #(.BAUD_DIV(BAUD_DIV)) u_phy (
    .clk      (xtal_in),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .rx_valid (rx_valid),
    .rx_data  (rx_byte),
    .tx_start (tx_start),
    .tx_data  (tx_byte),
    .tx_busy  (tx_busy)
  );

  assign fetch_rise = sw_sync[1] && !sw_prev;
  assign rx_take    = rx_valid && locked;
  assign led        = {locked, tx_busy, fetch_seen, ld_state != LD_IDLE};

  // Lock counter, fetch-enable synchroniser and sticky fetch indicator.
  always_ff @(posedge xtal_in) begin
    if (rst) begin
      lock_cnt   <= '0;
      locked     <= 1'b0;
      sw_sync    <= 2'b00;
      sw_prev    <= 1'b0;
      fetch_seen <= 1'b0;
    end else begin
      sw_sync <= {sw_sync[0], sw[3]};
      sw_prev <= sw_sync[1];
      if (!locked) begin
        lock_cnt <= lock_cnt + LCW'(1);
        if (lock_cnt == LCW'(LOCK_CYCLES - 1)) locked <= 1'b1;
      end
      if (fetch_rise && locked) fetch_seen <= 1'b1;
    end
  end

  // Loader state register.
  always_ff @(posedge xtal_in) begin
    if (rst) ld_state <= LD_IDLE;
    else     ld_state <= ld_next;
  end

  // Loader next-state: address capture, word assembly, repeated-header filter.
  always_comb begin
    ld_next      = ld_state;
    addr_next    = ld_addr;
    word_next    = ld_word;
    cnt_next     = ld_cnt;
    first_next   = first_word;
    held_next    = held;
    wr_en_next   = 1'b0;
    wr_idx_next  = wr_idx;
    wr_data_next = wr_data;
    addr_inc     = ld_addr + 32'd4;
    if (rx_take) begin
      unique case (ld_state)
        LD_IDLE:  if (rx_byte == CMD_WRITE) ld_next = LD_ADDR0;
        LD_ADDR0: begin addr_next[31:24] = rx_byte; ld_next = LD_ADDR1; end
        LD_ADDR1: begin addr_next[23:16] = rx_byte; ld_next = LD_ADDR2; end
        LD_ADDR2: begin addr_next[15:8]  = rx_byte; ld_next = LD_ADDR3; end
        LD_ADDR3: begin
          addr_next[7:0] = rx_byte;
          ld_next        = LD_DATA;
          cnt_next       = 2'd0;
          first_next     = 1'b1;
          held_next      = 1'b0;
        end
        LD_DATA: begin
          if (held) begin
            held_next  = 1'b0;
            first_next = 1'b0;
            if (rx_byte == ld_addr[7:0]) begin
              cnt_next = 2'd0;
            end else begin
              wr_en_next   = 1'b1;
              wr_idx_next  = ld_addr[AW+1:2];
              wr_data_next = ld_word;
              addr_next    = addr_inc;
              word_next    = {24'd0, rx_byte};
              cnt_next     = 2'd1;
              if (addr_inc[3:0] == 4'd0) ld_next = LD_IDLE;
            end
          end else begin
            word_next = {ld_word[23:0], rx_byte};
            if (ld_cnt == 2'd3) begin
              cnt_next = 2'd0;
              if (first_word && ({ld_word[23:0], rx_byte} == {CMD_WRITE, ld_addr[31:8]})) begin
                held_next = 1'b1;
              end else begin
                first_next   = 1'b0;
                wr_en_next   = 1'b1;
                wr_idx_next  = ld_addr[AW+1:2];
                wr_data_next = {ld_word[23:0], rx_byte};
                addr_next    = addr_inc;
                if (addr_inc[3:0] == 4'd0) ld_next = LD_IDLE;
              end
            end else begin
              cnt_next = ld_cnt + 2'd1;
            end
          end
        end
        default: ld_next = LD_IDLE;
      endcase
    end
  end

  // Loader control registers; reset discards any partial word or pending write.
  always_ff @(posedge xtal_in) begin
    if (rst) begin
      ld_cnt     <= 2'd0;
      first_word <= 1'b0;
      held       <= 1'b0;
      wr_en      <= 1'b0;
    end else begin
      ld_cnt     <= cnt_next;
      first_word <= first_next;
      held       <= held_next;
      wr_en      <= wr_en_next;
    end
  end

  // Loader and dump datapath registers.
  always_ff @(posedge xtal_in) begin
    ld_addr <= addr_next;
    ld_word <= word_next;
    wr_idx  <= wr_idx_next;
    wr_data <= wr_data_next;
    rd_idx  <= rd_idx_next;
    dp_bidx <= bidx_next;
    if (dp_state == DP_LOAD) dp_word <= rd_data;
  end

  // Single-port RAM; a pending loader write wins over a dump read.
  always_ff @(posedge xtal_in) begin
    if (wr_en)       mem[wr_idx] <= wr_data;
    else if (rd_req) rd_data     <= mem[rd_idx];
  end

  // Dump state register.
  always_ff @(posedge xtal_in) begin
    if (rst) dp_state <= DP_IDLE;
    else     dp_state <= dp_next;
  end

  // Dump next-state: read word, send bytes MSB first, stop at a zero byte or last word.
  always_comb begin
    dp_next     = dp_state;
    rd_idx_next = rd_idx;
    bidx_next   = dp_bidx;
    rd_req      = 1'b0;
    tx_start    = 1'b0;
    tx_byte     = 8'd0;
    unique case (dp_bidx)
      2'd0: tx_byte = dp_word[31:24];
      2'd1: tx_byte = dp_word[23:16];
      2'd2: tx_byte = dp_word[15:8];
      default: tx_byte = dp_word[7:0];
    endcase
    unique case (dp_state)
      DP_IDLE: if (fetch_rise && locked) begin
        dp_next     = DP_READ;
        rd_idx_next = '0;
      end
      DP_READ: begin
        rd_req = 1'b1;
        if (!wr_en) dp_next = DP_LOAD;
      end
      DP_LOAD: begin
        bidx_next = 2'd0;
        dp_next   = DP_SEND;
      end
      DP_SEND: begin
        if (tx_byte == 8'd0) begin
          dp_next = DP_IDLE;
        end else if (!tx_busy) begin
          tx_start = 1'b1;
          if (dp_bidx == 2'd3) begin
            if (rd_idx == AW'(MEM_WORDS - 1)) begin
              dp_next = DP_IDLE;
            end else begin
              rd_idx_next = rd_idx + AW'(1);
              dp_next     = DP_READ;
            end
          end else begin
            bidx_next = dp_bidx + 2'd1;
          end
        end
      end
      default: dp_next = DP_IDLE;
    endcase
  end

endmodule

// File: tb/tb_arty_uart_loader_top.sv
// Directed bench for the Arty UART loader: load frames, repeated header, aliasing, dump.
`timescale 1ns/1ps
module tb_arty_uart_loader_top;
  import arty_pkg::*;

  localparam int BIT     = 16;
  localparam int LOCK    = 64;
  localparam int TIMEOUT = 4000;

  logic       xtal = 1'b0;
  logic [3:0] btn;
  logic [3:0] sw;
  logic       uart_rx;
  logic       uart_tx;
  logic [3:0] led;

  int checks   = 0;
  int failures = 0;
  int lows;
  logic [7:0] rb;
  bit         rok;
  bit         rbusy;
  logic [7:0] exp_dump [3];

  arty_uart_loader_top #(
    .CLK_FREQ_HZ (1_600_000),
    .BAUD_RATE   (100_000),
    .MEM_WORDS   (4096),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .xtal_in (xtal),
    .btn     (btn),
    .sw      (sw),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .led     (led)
  );

  always #5 xtal = ~xtal;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge xtal);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge xtal);
    end
    uart_rx = good_stop;
    repeat (BIT) @(negedge xtal);
    uart_rx = 1'b1;
    repeat (BIT) @(negedge xtal);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[15:8],  1'b1);
    send_byte(w[7:0],   1'b1);
  endtask

  task automatic send_hdr(input logic [31:0] a);
    send_byte(8'h02, 1'b1);
    send_word(a);
  endtask

  task automatic do_reset();
    btn = 4'b1000;
    repeat (3) @(negedge xtal);
    btn = 4'b0000;
    repeat (LOCK + 2) @(negedge xtal);
  endtask

  task automatic recv_byte(output logic [7:0] b, output bit ok, output bit busy);
    int n = 0;
    ok   = 1'b0;
    busy = 1'b0;
    b    = 8'h00;
    while (uart_tx !== 1'b0 && n < TIMEOUT) begin
      @(negedge xtal);
      n++;
    end
    if (uart_tx === 1'b0) begin
      repeat (BIT / 2) @(negedge xtal);
      busy = led[2];
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge xtal);
        b[i] = uart_tx;
      end
      repeat (BIT) @(negedge xtal);
      ok = (uart_tx === 1'b1);
    end
  endtask

  initial begin
    btn     = 4'b1000;
    sw      = 4'b0000;
    uart_rx = 1'b1;
    exp_dump[0] = 8'h48;
    exp_dump[1] = 8'h69;
    exp_dump[2] = 8'h0A;

    #150;
    chk("rst_led", led, 32'h0);
    chk("rst_tx", uart_tx, 32'h1);
    @(negedge xtal);
    btn = 4'b0000;
    repeat (LOCK - 1) @(negedge xtal);
    chk("lock_early", led[3], 32'h0);
    @(negedge xtal);
    chk("lock_led3", led[3], 32'h1);
    chk("idle_tx", uart_tx, 32'h1);
    chk("idle_led", led[2:0], 32'h0);

    // Full aligned frame at address 0.
    send_hdr(32'h0000_0000);
    send_word(32'h1122_3344);
    send_word(32'h5566_7788);
    send_word(32'h99AA_BBCC);
    send_word(32'hDDEE_FF00);
    repeat (4) @(negedge xtal);
    chk("f1_mem0", dut.mem[0], 32'h1122_3344);
    chk("f1_mem1", dut.mem[1], 32'h5566_7788);
    chk("f1_mem2", dut.mem[2], 32'h99AA_BBCC);
    chk("f1_mem3", dut.mem[3], 32'hDDEE_FF00);
    chk("f1_idle", led[0], 32'h0);

    // Frame starting mid-block ends at the 0x10 boundary; next 0x02 is a command.
    send_hdr(32'h0000_0008);
    send_word(32'hCAFE_BABE);
    send_word(32'h0BAD_F00D);
    send_hdr(32'h0000_0010);
    send_word(32'h0101_0101);
    send_word(32'h0202_0202);
    send_word(32'h0303_0303);
    send_word(32'h0404_0404);
    repeat (4) @(negedge xtal);
    chk("f2_mem2", dut.mem[2], 32'hCAFE_BABE);
    chk("f2_mem3", dut.mem[3], 32'h0BAD_F00D);
    chk("f2_mem4", dut.mem[4], 32'h0101_0101);
    chk("f2_mem7", dut.mem[7], 32'h0404_0404);
    chk("f2_idle", led[0], 32'h0);

    // Repeated header with an aliased address, then one word.
    send_hdr(32'h0010_0000);
    send_hdr(32'h0010_0000);
    send_word(32'h0000_ABCD);
    repeat (4) @(negedge xtal);
    chk("dup_mem0", dut.mem[0], 32'h0000_ABCD);
    chk("dup_mem1", dut.mem[1], 32'h5566_7788);
    chk("dup_midframe", led[0], 32'h1);

    // Reset with a partial word outstanding.
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    do_reset();
    chk("rstmid_mem1", dut.mem[1], 32'h5566_7788);
    chk("rstmid_idle", led[0], 32'h0);

    // Framing error during the second address byte.
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (4) @(negedge xtal);
    chk("ferr_state", 32'(dut.ld_state), 32'(LD_ADDR1));
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h20, 1'b1);
    send_word(32'h1357_9BDF);
    repeat (4) @(negedge xtal);
    chk("ferr_mem8", dut.mem[8], 32'h1357_9BDF);

    // Console dump of "Hi\n\0".
    do_reset();
    send_hdr(32'h0000_0000);
    send_word(32'h4869_0A00);
    repeat (4) @(negedge xtal);
    chk("dump_mem0", dut.mem[0], 32'h4869_0A00);
    sw = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      recv_byte(rb, rok, rbusy);
      chk($sformatf("dump_byte%0d", k), rb, exp_dump[k]);
      chk($sformatf("dump_stop%0d", k), rok, 32'h1);
      chk($sformatf("dump_busy%0d", k), rbusy, 32'h1);
    end
    lows = 0;
    repeat (20 * BIT) begin
      @(negedge xtal);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("dump_quiet", lows, 32'h0);
    chk("dump_led1", led[1], 32'h1);
    chk("dump_led2_off", led[2], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
